// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock for the 5-stage filter processor: load-use bubbles, branch flushes, memory-wait freeze.
// Optional build macro STALL_STATS_EN adds the stall_cycles / flush_events counters.
module hazard_stall_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Ra_F_Reg,
  input  logic [3:0] Rb_F_Reg,
  input  logic       RE_A_F_Reg,
  input  logic       RE_B_F_Reg,
  input  logic       mem_RE_Reg_Exe,
  input  logic [3:0] Robj_Reg_Exe,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       en_F_Reg,
  output logic       en_Reg_Exe,
  output logic       en_Exe_Mem,
  output logic       en_Mem_WB,
  output logic       flush_F_Reg,
  output logic       flush_Reg_Exe,
  output logic       mem_timeout
`ifdef STALL_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE_C = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO_C = WAIT_W'(0);
  localparam logic [2:0] LU_LAST_C = 3'(LU_STALL_CYCLES - 1);
  localparam bit LU_MULTI_C = (LU_STALL_CYCLES > 1);

  // Control vector order: {pc_en, en_F_Reg, en_Reg_Exe, en_Exe_Mem, en_Mem_WB, flush_F_Reg, flush_Reg_Exe}
  localparam logic [6:0] CTL_RUN_C    = 7'b1111100;
  localparam logic [6:0] CTL_FREEZE_C = 7'b0000000;
  localparam logic [6:0] CTL_BRANCH_C = 7'b1111111;
  localparam logic [6:0] CTL_LU_C     = 7'b0011101;
  localparam logic [6:0] CTL_RESET_C  = 7'b0000011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  state_t            rel_state_s;
  logic [2:0]        lu_cnt_r;
  logic [2:0]        lu_cnt_nxt_s;
  logic [2:0]        rel_lu_cnt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              mem_timeout_r;
  logic              timeout_set_s;
  logic              frozen_s;
  logic              lu_hz_s;
  logic              mw_s;
  logic [6:0]        ctl_s;
  logic [6:0]        rel_ctl_s;
  logic [6:0]        ctl_out_s;

  function automatic logic src_match(input logic re, input logic [3:0] src, input logic [3:0] dst);
    return re & (src == dst);
  endfunction

  assign lu_hz_s = mem_RE_Reg_Exe &
                   (src_match(RE_A_F_Reg, Ra_F_Reg, Robj_Reg_Exe) |
                    src_match(RE_B_F_Reg, Rb_F_Reg, Robj_Reg_Exe));
  assign mw_s    = mem_req & ~mem_ready;

  // RUN-style evaluation with the memory-wait term removed; shared by RUN and by wait release.
  always_comb begin
    rel_ctl_s    = CTL_RUN_C;
    rel_state_s  = RUN;
    rel_lu_cnt_s = 3'd0;
    if (branch_taken) begin
      rel_ctl_s = CTL_BRANCH_C;
    end else if (lu_hz_s) begin
      rel_ctl_s = CTL_LU_C;
      if (LU_MULTI_C) begin
        rel_state_s  = LU_STALL;
        rel_lu_cnt_s = 3'd1;
      end else begin
        rel_state_s  = RUN;
        rel_lu_cnt_s = 3'd0;
      end
    end else begin
      rel_ctl_s = CTL_RUN_C;
    end
  end

  // Next-state, counter updates and pipeline control for the current state.
  always_comb begin
    ctl_s          = CTL_RUN_C;
    state_nxt_s    = state_r;
    lu_cnt_nxt_s   = lu_cnt_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_set_s  = 1'b0;
    frozen_s       = 1'b0;
    case (state_r)
      RUN: begin
        if (mw_s) begin
          ctl_s          = CTL_FREEZE_C;
          frozen_s       = 1'b1;
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = WAIT_ONE_C;
          lu_cnt_nxt_s   = 3'd0;
        end else begin
          ctl_s          = rel_ctl_s;
          state_nxt_s    = rel_state_s;
          lu_cnt_nxt_s   = rel_lu_cnt_s;
          wait_cnt_nxt_s = WAIT_ZERO_C;
        end
      end
      LU_STALL: begin
        if (mw_s) begin
          ctl_s          = CTL_FREEZE_C;
          frozen_s       = 1'b1;
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = WAIT_ONE_C;
          lu_cnt_nxt_s   = 3'd0;
        end else if (branch_taken) begin
          ctl_s        = CTL_BRANCH_C;
          state_nxt_s  = RUN;
          lu_cnt_nxt_s = 3'd0;
        end else begin
          ctl_s = CTL_LU_C;
          if (lu_cnt_r == LU_LAST_C) begin
            state_nxt_s  = RUN;
            lu_cnt_nxt_s = 3'd0;
          end else begin
            state_nxt_s  = LU_STALL;
            lu_cnt_nxt_s = lu_cnt_r + 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        // Branch and load-use inputs are held by the frozen pipeline, so only release matters here.
        if (!mem_ready && (wait_cnt_r < TIMEOUT_C)) begin
          ctl_s          = CTL_FREEZE_C;
          frozen_s       = 1'b1;
          wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE_C;
        end else begin
          timeout_set_s  = ~mem_ready;
          ctl_s          = rel_ctl_s;
          state_nxt_s    = rel_state_s;
          lu_cnt_nxt_s   = rel_lu_cnt_s;
          wait_cnt_nxt_s = WAIT_ZERO_C;
        end
      end
      default: begin
        ctl_s          = CTL_RESET_C;
        state_nxt_s    = RUN;
        lu_cnt_nxt_s   = 3'd0;
        wait_cnt_nxt_s = WAIT_ZERO_C;
      end
    endcase
  end

  // Reset forces the whole pipeline to hold and load bubbles.
  always_comb begin
    if (!rst_n) begin
      ctl_out_s = CTL_RESET_C;
    end else begin
      ctl_out_s = ctl_s;
    end
  end

  assign pc_en         = ctl_out_s[6];
  assign en_F_Reg      = ctl_out_s[5];
  assign en_Reg_Exe    = ctl_out_s[4];
  assign en_Exe_Mem    = ctl_out_s[3];
  assign en_Mem_WB     = ctl_out_s[2];
  assign flush_F_Reg   = ctl_out_s[1];
  assign flush_Reg_Exe = ctl_out_s[0];
  assign mem_timeout   = mem_timeout_r;

  // State, counters and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= RUN;
      lu_cnt_r      <= 3'd0;
      wait_cnt_r    <= WAIT_ZERO_C;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      lu_cnt_r      <= lu_cnt_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      mem_timeout_r <= mem_timeout_r | timeout_set_s;
    end
  end

`ifdef STALL_STATS_EN
  logic [15:0] stall_cycles_r;
  logic [15:0] flush_events_r;

  // Saturating event counters; in this branch rst_n is high, so ctl_s is what the pipeline sees.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_r <= 16'h0000;
      flush_events_r <= 16'h0000;
    end else begin
      if (!ctl_s[6] && (stall_cycles_r != 16'hFFFF)) begin
        stall_cycles_r <= stall_cycles_r + 16'h0001;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (ctl_s[1] && (flush_events_r != 16'hFFFF)) begin
        flush_events_r <= flush_events_r + 16'h0001;
      end else begin
        flush_events_r <= flush_events_r;
      end
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign flush_events = flush_events_r;
`endif

  hazard_stall_ctrl_chk u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .frozen        (frozen_s),
    .pc_en         (pc_en),
    .en_F_Reg      (en_F_Reg),
    .en_Reg_Exe    (en_Reg_Exe),
    .en_Exe_Mem    (en_Exe_Mem),
    .en_Mem_WB     (en_Mem_WB),
    .flush_F_Reg   (flush_F_Reg),
    .flush_Reg_Exe (flush_Reg_Exe)
  );

endmodule

// Invariant checks on the pipeline control lines; no functional logic.
module hazard_stall_ctrl_chk (
  input logic clk,
  input logic rst_n,
  input logic frozen,
  input logic pc_en,
  input logic en_F_Reg,
  input logic en_Reg_Exe,
  input logic en_Exe_Mem,
  input logic en_Mem_WB,
  input logic flush_F_Reg,
  input logic flush_Reg_Exe
);

  // Reg/Exe may run ahead of a held F/Reg only when it is being bubbled.
  a_enable_order: assert property (@(posedge clk) disable iff (!rst_n)
    (pc_en | ~en_F_Reg) && (en_F_Reg | ~en_Reg_Exe | flush_Reg_Exe) &&
    (en_Reg_Exe | ~en_Exe_Mem) && (en_Exe_Mem | ~en_Mem_WB));

  a_no_flush_frozen: assert property (@(posedge clk) disable iff (!rst_n)
    frozen |-> (~flush_F_Reg & ~flush_Reg_Exe));

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: default instance plus a 3-bubble load-use instance on shared inputs.
module tb_hazard_stall_ctrl;

  localparam logic [6:0] C_RUN    = 7'b1111100;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_BRANCH = 7'b1111111;
  localparam logic [6:0] C_LU     = 7'b0011101;
  localparam logic [6:0] C_RESET  = 7'b0000011;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] Ra_F_Reg, Rb_F_Reg, Robj_Reg_Exe;
  logic RE_A_F_Reg, RE_B_F_Reg, mem_RE_Reg_Exe, branch_taken, mem_req, mem_ready;

  logic pc_en1, enf1, enr1, ene1, enm1, flf1, flr1, to1;
  logic pc_en3, enf3, enr3, ene3, enm3, flf3, flr3, to3;
  logic [6:0] ctl1, ctl3;
`ifdef STALL_STATS_EN
  logic [15:0] sc1, fe1, sc3, fe3;
  logic [15:0] sc3_snap;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ctl1 = {pc_en1, enf1, enr1, ene1, enm1, flf1, flr1};
  assign ctl3 = {pc_en3, enf3, enr3, ene3, enm3, flf3, flr3};

  hazard_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Ra_F_Reg(Ra_F_Reg), .Rb_F_Reg(Rb_F_Reg),
    .RE_A_F_Reg(RE_A_F_Reg), .RE_B_F_Reg(RE_B_F_Reg), .mem_RE_Reg_Exe(mem_RE_Reg_Exe),
    .Robj_Reg_Exe(Robj_Reg_Exe), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_en(pc_en1), .en_F_Reg(enf1), .en_Reg_Exe(enr1),
    .en_Exe_Mem(ene1), .en_Mem_WB(enm1), .flush_F_Reg(flf1), .flush_Reg_Exe(flr1),
    .mem_timeout(to1)
`ifdef STALL_STATS_EN
    , .stall_cycles(sc1), .flush_events(fe1)
`endif
  );

  hazard_stall_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(15)) dut3 (
    .clk(clk), .rst_n(rst_n), .Ra_F_Reg(Ra_F_Reg), .Rb_F_Reg(Rb_F_Reg),
    .RE_A_F_Reg(RE_A_F_Reg), .RE_B_F_Reg(RE_B_F_Reg), .mem_RE_Reg_Exe(mem_RE_Reg_Exe),
    .Robj_Reg_Exe(Robj_Reg_Exe), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_en(pc_en3), .en_F_Reg(enf3), .en_Reg_Exe(enr3),
    .en_Exe_Mem(ene3), .en_Mem_WB(enm3), .flush_F_Reg(flf3), .flush_Reg_Exe(flr3),
    .mem_timeout(to3)
`ifdef STALL_STATS_EN
    , .stall_cycles(sc3), .flush_events(fe3)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle to mid-cycle (falling edge) before sampling.
  task automatic settle();
    #4;
  endtask

  task automatic idle();
    Ra_F_Reg = 4'd0; Rb_F_Reg = 4'd0; Robj_Reg_Exe = 4'd0;
    RE_A_F_Reg = 1'b0; RE_B_F_Reg = 1'b0; mem_RE_Reg_Exe = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic ld, input logic [3:0] robj, input logic rea, input logic [3:0] ra,
                        input logic reb, input logic [3:0] rb);
    mem_RE_Reg_Exe = ld; Robj_Reg_Exe = robj;
    RE_A_F_Reg = rea; Ra_F_Reg = ra; RE_B_F_Reg = reb; Rb_F_Reg = rb;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    settle();
    check_val("reset_ctl_pre_edge", {25'd0, ctl1}, {25'd0, C_RESET});
    tick();
    mem_req = 1'b1;
    settle();
    check_val("reset_ctl_mw", {25'd0, ctl1}, {25'd0, C_RESET});
    check_val("reset_timeout", {31'd0, to1}, 32'd0);
    tick();
    rst_n = 1'b1;
    idle();
    settle();
    check_val("run_idle", {25'd0, ctl1}, {25'd0, C_RUN});
    check_val("run_idle3", {25'd0, ctl3}, {25'd0, C_RUN});
    tick();

    // Load-use on source A; default instance stalls one cycle, dut3 three.
`ifdef STALL_STATS_EN
    sc3_snap = sc3;
`endif
    set_lu(1'b1, 4'd4, 1'b1, 4'd4, 1'b0, 4'd0);
    settle();
    check_val("lu_a", {25'd0, ctl1}, {25'd0, C_LU});
    check_val("lu_a3_c1", {25'd0, ctl3}, {25'd0, C_LU});
    tick();
    idle();
    settle();
    check_val("lu_a_after", {25'd0, ctl1}, {25'd0, C_RUN});
    check_val("lu_a3_c2", {25'd0, ctl3}, {25'd0, C_LU});
    tick();
    settle();
    check_val("lu_a3_c3", {25'd0, ctl3}, {25'd0, C_LU});
    tick();
    settle();
    check_val("lu_a3_done", {25'd0, ctl3}, {25'd0, C_RUN});
`ifdef STALL_STATS_EN
    check_val("stats_stall3", {16'd0, sc3 - sc3_snap}, 32'd3);
`endif
    tick();

    // Source B hazard, and non-hazard patterns (no read enable, no load, different register).
    set_lu(1'b1, 4'd7, 1'b0, 4'd7, 1'b1, 4'd7);
    settle();
    check_val("lu_b", {25'd0, ctl1}, {25'd0, C_LU});
    tick();
    set_lu(1'b1, 4'd9, 1'b0, 4'd9, 1'b0, 4'd9);
    settle();
    check_val("no_re", {25'd0, ctl1}, {25'd0, C_RUN});
    tick();
    set_lu(1'b0, 4'd2, 1'b1, 4'd2, 1'b1, 4'd2);
    settle();
    check_val("no_load", {25'd0, ctl1}, {25'd0, C_RUN});
    check_val("lu_b3_hold", {25'd0, ctl3}, {25'd0, C_LU});
    tick();
    set_lu(1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 4'd4);
    settle();
    check_val("reg_differ", {25'd0, ctl1}, {25'd0, C_RUN});
    check_val("reg_differ3", {25'd0, ctl3}, {25'd0, C_RUN});
    tick();

    // Branch together with load-use: flush both, no stall.
    set_lu(1'b1, 4'd4, 1'b1, 4'd4, 1'b0, 4'd0);
    branch_taken = 1'b1;
    settle();
    check_val("br_lu", {25'd0, ctl1}, {25'd0, C_BRANCH});
    check_val("br_lu3", {25'd0, ctl3}, {25'd0, C_BRANCH});
    tick();
    idle();
    settle();
    check_val("br_lu_after3", {25'd0, ctl3}, {25'd0, C_RUN});
    tick();

    // Branch arriving during LU_STALL aborts the remaining bubbles.
    set_lu(1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 4'd0);
    tick();
    idle();
    branch_taken = 1'b1;
    settle();
    check_val("br_in_lustall3", {25'd0, ctl3}, {25'd0, C_BRANCH});
    tick();
    idle();
    settle();
    check_val("br_in_lustall3_after", {25'd0, ctl3}, {25'd0, C_RUN});
    tick();

    // Memory wait of 3 cycles; a branch mid-wait is ignored.
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0;
      branch_taken = (i == 1);
      settle();
      check_val($sformatf("mw_frozen%0d", i), {25'd0, ctl1}, {25'd0, C_FREEZE});
      tick();
    end
    branch_taken = 1'b0;
    mem_ready = 1'b1;
    settle();
    check_val("mw_release", {25'd0, ctl1}, {25'd0, C_RUN});
    tick();
    idle();
    settle();
    check_val("mw_after", {25'd0, ctl1}, {25'd0, C_RUN});
    check_val("mw_no_timeout", {31'd0, to1}, 32'd0);
    tick();

    // Wait beats load-use; release then applies load-use.
    set_lu(1'b1, 4'd8, 1'b1, 4'd8, 1'b0, 4'd0);
    mem_req = 1'b1; mem_ready = 1'b0;
    settle();
    check_val("mw_over_lu", {25'd0, ctl1}, {25'd0, C_FREEZE});
    tick();
    mem_ready = 1'b1;
    settle();
    check_val("rel_lu", {25'd0, ctl1}, {25'd0, C_LU});
    check_val("rel_lu3", {25'd0, ctl3}, {25'd0, C_LU});
    tick();
    idle();
    settle();
    check_val("rel_lu_after", {25'd0, ctl1}, {25'd0, C_RUN});
    check_val("rel_lu3_c2", {25'd0, ctl3}, {25'd0, C_LU});
    tick();
    settle();
    check_val("rel_lu3_c3", {25'd0, ctl3}, {25'd0, C_LU});
    tick();
    settle();
    check_val("rel_lu3_done", {25'd0, ctl3}, {25'd0, C_RUN});
    tick();

    // Timeout: 15 frozen cycles then forced release, sticky flag afterwards.
    for (int i = 0; i < 15; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0;
      settle();
      check_val($sformatf("to_frozen%0d", i), {25'd0, ctl1}, {25'd0, C_FREEZE});
      tick();
    end
    settle();
    check_val("to_release", {25'd0, ctl1}, {25'd0, C_RUN});
    check_val("to_flag_not_yet", {31'd0, to1}, 32'd0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      check_val($sformatf("to_sticky%0d", i), {31'd0, to1}, 32'd1);
      check_val($sformatf("to_run%0d", i), {25'd0, ctl1}, {25'd0, C_RUN});
      tick();
    end

    // Reset in the middle of a wait (wait_cnt reaches 5).
    for (int i = 0; i < 5; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0;
      tick();
    end
    settle();
    check_val("mid_wait_frozen", {25'd0, ctl1}, {25'd0, C_FREEZE});
    rst_n = 1'b0;
    #1;
    check_val("mid_wait_reset_ctl", {25'd0, ctl1}, {25'd0, C_RESET});
    tick();
    settle();
    check_val("rst_clears_timeout", {31'd0, to1}, 32'd0);
    check_val("rst_low_ctl", {25'd0, ctl1}, {25'd0, C_RESET});
    tick();
    rst_n = 1'b1;
    idle();
    settle();
    check_val("post_rst_run", {25'd0, ctl1}, {25'd0, C_RUN});
    check_val("post_rst_timeout", {31'd0, to1}, 32'd0);
`ifdef STALL_STATS_EN
    check_val("stats_rst_clear", {16'd0, sc1}, 32'd0);
`endif
    tick();
    mem_req = 1'b1; mem_ready = 1'b0;
    settle();
    check_val("post_rst_fresh_wait", {25'd0, ctl1}, {25'd0, C_FREEZE});
    tick();
    idle();
    mem_ready = 1'b1;
    settle();
    check_val("post_rst_release", {25'd0, ctl1}, {25'd0, C_RUN});
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline interlock controller for the 5-stage filter processor (F, Reg, Exe, Mem, WB).
- Complements the forwarding unit. It handles the hazards forwarding cannot resolve:
  - load-use stalls,
  - taken-branch flushes,
  - multi-cycle data-memory waits, with a timeout.
- Drives the PC enable and per-pipeline-register enable/flush lines.

Parameters:
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
MEM_TIMEOUT, 15, max MEM_WAIT cycles before forced release (2..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
Ra_F_Reg  in  4  source A of instruction in F/Reg
Rb_F_Reg  in  4  source B of instruction in F/Reg
RE_A_F_Reg  in  1  instruction in F/Reg reads A
RE_B_F_Reg  in  1  instruction in F/Reg reads B
mem_RE_Reg_Exe  in  1  instruction in Reg/Exe is a load
Robj_Reg_Exe  in  4  destination of instruction in Reg/Exe
branch_taken  in  1  branch resolved taken in Exe
mem_req  in  1  Mem stage issues data-memory access
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC update enable
en_F_Reg  out  1  F/Reg register enable
en_Reg_Exe  out  1  Reg/Exe register enable
en_Exe_Mem  out  1  Exe/Mem register enable
en_Mem_WB  out  1  Mem/WB register enable
flush_F_Reg  out  1  load NOP into F/Reg at next edge
flush_Reg_Exe  out  1  load NOP into Reg/Exe at next edge
mem_timeout  out  1  sticky: a memory wait expired

Behaviour:
- State is registered; outputs are combinational from state plus current inputs, so a stall or flush acts in the cycle it is detected.
- States: RUN, LU_STALL, MEM_WAIT.
- Counters:
  - lu_cnt, 3 bits.
  - wait_cnt, $clog2(MEM_TIMEOUT+1) bits.
- Reset (rst_n=0 at edge):
  - State becomes RUN; lu_cnt=0, wait_cnt=0, mem_timeout=0.
  - While rst_n is low, outputs are: all enables 0, both flushes 1.
  - Reset overrides any state, including mid-wait.
- Hazard term: lu_hz = mem_RE_Reg_Exe & ((RE_A_F_Reg & Ra_F_Reg==Robj_Reg_Exe) | (RE_B_F_Reg & Rb_F_Reg==Robj_Reg_Exe)).
- Memory-wait term: mw = mem_req & ~mem_ready.
- Priority within a cycle: mw > branch_taken > lu_hz.
- RUN:
  - mw: all enables 0, flushes 0; go to MEM_WAIT with wait_cnt=1.
  - branch_taken: all enables 1, flush_F_Reg=1, flush_Reg_Exe=1. No stall, since the F/Reg instruction is wrong-path.
  - lu_hz:
    - pc_en=0, en_F_Reg=0, flush_Reg_Exe=1, en_Exe_Mem=1, en_Mem_WB=1.
    - If LU_STALL_CYCLES>1, go to LU_STALL with lu_cnt=1; else stay in RUN.
  - Otherwise: all enables 1, flushes 0.
- LU_STALL:
  - Outputs are the same as the lu_hz case, with priority still applied: mw goes to MEM_WAIT; branch_taken flushes and returns to RUN.
  - lu_cnt increments; at lu_cnt==LU_STALL_CYCLES-1, return to RUN.
- MEM_WAIT:
  - While ~mem_ready and wait_cnt<MEM_TIMEOUT: all enables 0, flushes 0, wait_cnt++.
  - branch_taken and lu_hz are ignored, because the pipeline is frozen and they hold stable.
  - mem_ready=1: release. This cycle's outputs equal RUN evaluation with mw=0; next state is RUN, or LU_STALL per the RUN rules. wait_cnt clears.
  - wait_cnt==MEM_TIMEOUT with ~mem_ready: set mem_timeout (sticky until reset) and release exactly as for mem_ready.
- Invariants:
  - A stage enable is never 0 while a later stage's enable is 1, except Reg/Exe during lu_hz, which is bubbled via flush.
  - Flushes never assert in MEM_WAIT before release.

Optional Feature:
STALL_STATS_EN
- Defined:
  - Adds outputs stall_cycles [15:0] and flush_events [15:0].
  - stall_cycles counts cycles with rst_n=1 and pc_en=0.
  - flush_events counts cycles with flush_F_Reg=1 and rst_n=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: Reg/Exe load with Robj=4; F/Reg has Ra=4, RE_A=1 -> pc_en=0, en_F_Reg=0, flush_Reg_Exe=1 for 1 cycle; next cycle all enables 1.
- Branch plus load-use together: branch_taken=1 with lu_hz=1 -> pc_en=1, both flushes 1, no stall cycle.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles; release cycle all enables 1; mem_timeout stays 0.
- Timeout: mem_req=1, mem_ready held 0 -> after 15 frozen cycles, release; mem_timeout=1 and holds until rst_n=0.
- Reset mid-operation: rst_n=0 during MEM_WAIT (wait_cnt=5) -> next cycle state RUN, mem_timeout=0, flushes 1 while low; after release, normal RUN.
- LU_STALL_CYCLES=3: load-use -> exactly 3 consecutive pc_en=0 cycles. With STALL_STATS_EN, stall_cycles increments by 3.
